// File: rtl/mesh_term_rx.sv
// mesh_term_rx: terminal endpoint on one external mesh port.
// Pops packets from the mesh with a fall-through pop protocol and checks
// each packet's destination. Accepted packets go into a small FIFO, which a
// local consumer drains over valid/ready. Misrouted packets are dropped and
// counted in a saturating counter.
//
// Handshakes:
//   mesh side : mesh_data is valid while mesh_pndng=1. The block samples
//               mesh_data on the rising edge that ends a cycle with
//               mesh_pop=1, and the mesh advances its head on that same edge.
//               mesh_pop is never high while mesh_pndng=0.
//   rx side   : a transfer happens on every rising edge where rx_valid=1 and
//               rx_ready=1. rx_data and rx_bdcst hold steady while
//               rx_valid=1 and rx_ready=0.
module mesh_term_rx #(
  parameter int         pckg_sz    = 41,
  parameter int         fifo_depth = 8,
  parameter int         MY_ROW     = 0,
  parameter int         MY_COL     = 0,
  parameter logic [7:0] bdcst      = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mesh_pndng,
  input  logic [pckg_sz-1:0] mesh_data,
  output logic               mesh_pop,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_bdcst,
  input  logic               rx_ready,
  input  logic               clr_cnt,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        err_cnt,
  output logic [1:0]         dbg_state
);

  localparam int         AW      = $clog2(fifo_depth);
  localparam int         EW      = pckg_sz + 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(fifo_depth);
  localparam logic [3:0] ROW_ID  = 4'(MY_ROW);
  localparam logic [3:0] COL_ID  = 4'(MY_COL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               run_q, run_d;
  logic [pckg_sz-1:0] cap_q, cap_d;
  logic [EW-1:0]      mem_q [fifo_depth];
  logic [EW-1:0]      mem_d [fifo_depth];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic               pop_en;
  logic               in_capt;
  logic               is_bc;
  logic               is_match;
  logic               wr_en;
  logic               drop_en;
  logic               rd_en;
  logic               wr_ok;
  logic               full;
  logic [AW:0]        occ_eff;
  logic [7:0]         cap_nj;
  logic [3:0]         cap_row;
  logic [3:0]         cap_col;
  logic [EW-1:0]      head;

  // Destination classification of the packet captured on the pop edge.
  always_comb begin
    cap_nj   = cap_q[pckg_sz-1 -: 8];
    cap_row  = cap_q[pckg_sz-9 -: 4];
    cap_col  = cap_q[pckg_sz-13 -: 4];
    in_capt  = (state_q == ST_CAPT);
    is_bc    = (cap_nj == bdcst);
    is_match = (cap_row == ROW_ID) && (cap_col == COL_ID);
    wr_en    = in_capt && (is_bc || is_match);
    drop_en  = in_capt && !(is_bc || is_match);
  end

  // Occupancy as seen by the intake decision. A write still pending in CAPT
  // counts as occupied, so a pop can never overrun the buffer.
  always_comb begin
    occ_eff = cnt_q + (AW+1)'(wr_en);
    full    = (occ_eff >= DEPTH_L);
  end

  // Intake FSM: IDLE pops one packet, CAPT classifies it and GAP lets the
  // mesh present its next head. run_q keeps the pop low until the first
  // clock edge after reset is released.
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    pop_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_q && mesh_pndng && !full) begin
          pop_en  = 1'b1;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The capture register loads on the same edge that ends the pop cycle.
  always_comb begin
    cap_d = cap_q;
    if (pop_en) begin
      cap_d = mesh_data;
    end
  end

  // FIFO next state. A write and a read in the same cycle both happen.
  // A write into a full buffer goes ahead only when that read frees a slot.
  always_comb begin
    mem_d    = mem_q;
    rd_en    = rx_valid && rx_ready;
    wr_ok    = wr_en && ((cnt_q != DEPTH_L) || rd_en);
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    cnt_d    = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_en);
    if (wr_ok) begin
      mem_d[wr_ptr_q] = {is_bc, cap_q};
    end
  end

  // Saturating counters. clr_cnt wins over an increment in the same cycle.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (wr_ok && (pkt_cnt_q != 16'hFFFF)) begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
      if (drop_en && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  // FSM and capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cap_q   <= cap_d;
    end
  end

  // FIFO storage and pointers. Storage is cleared so rx_data reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Output mapping. The head entry is read straight from storage.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    mesh_pop  = pop_en;
    rx_valid  = (cnt_q != '0);
    rx_data   = head[pckg_sz-1:0];
    rx_bdcst  = head[pckg_sz];
    pkt_cnt   = pkt_cnt_q;
    err_cnt   = err_cnt_q;
    dbg_state = state_q;
  end

endmodule
